// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer sharing one external ripple adder among NREQ clients.
// Latches the winner's operands, waits one settle cycle, returns sum/carry tagged with its ID.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_cout,
  output logic                  done,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic [IDW-1:0]        res_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] req_rot;
  logic            found;
  int unsigned     idx;

  // Scan ptr, ptr+1, ... wrapping at NREQ; first set request wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    req_rot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      req_rot = req >> idx;
      if (!found && req_rot[0]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= win_oh;
            add_a  <= op_a[win*WIDTH +: WIDTH];
            add_b  <= op_b[win*WIDTH +: WIDTH];
            res_id <= win;
          end else begin
            gnt <= '0;
          end
        end
        EXEC: begin
          res_sum  <= add_s;
          res_cout <= add_cout;
          done     <= 1'b1;
          ptr      <= (res_id == IDW'(NREQ-1)) ? '0 : res_id + 1'b1;
        end
        RESP: begin
          done <= 1'b0;
          gnt  <= '0;
        end
        default: begin
          done <= 1'b0;
          gnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: table-driven single requests plus round-robin, wrap, and reset corners.
module tb_adder_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] op_a, op_b;
  logic [3:0]  gnt;
  logic        busy;
  logic [2:0]  add_a, add_b, add_s;
  logic        add_cout;
  logic        done;
  logic [2:0]  res_sum;
  logic        res_cout;
  logic [1:0]  res_id;

  adder_share_arb #(.NREQ(4), .WIDTH(3), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_s(add_s), .add_cout(add_cout), .done(done),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
  );

  // The shared external adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int id; int sum; int cout;} exp_t;
  typedef struct {int id; int a; int b; int sum; int cout;} vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   compared;
  int   mismatched;

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int id);
    logic [3:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  task automatic set_ops(input int id, input int a, input int b);
    op_a[id*3 +: 3] = 3'(a);
    op_b[id*3 +: 3] = 3'(b);
  endtask

  task automatic push(input int id, input int sum, input int cout);
    exp_t e;
    e.id = id; e.sum = sum; e.cout = cout;
    sb.push_back(e);
  endtask

  // Advance one cycle; sample at the falling edge and retire any result.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cmp("gnt_onehot0", int'($onehot0(gnt)), 1);
    cmp("busy_vs_gnt", int'(busy), int'(gnt != 4'b0));
    if (done) begin
      if (sb.size() == 0) begin
        cmp("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        cmp("res_id", int'(res_id), e.id);
        cmp("res_sum", int'(res_sum), e.sum);
        cmp("res_cout", int'(res_cout), e.cout);
      end
    end
  endtask

  task automatic single(input int id, input int a, input int b, input int sum, input int cout);
    set_ops(id, a, b);
    req = oh(id);
    push(id, sum, cout);
    step();
    cmp("grant1", int'(gnt), int'(oh(id)));
    cmp("done_early", int'(done), 0);
    cmp("add_a", int'(add_a), a);
    cmp("add_b", int'(add_b), b);
    op_a = 12'($urandom);
    op_b = 12'($urandom);
    step();
    cmp("grant2", int'(gnt), int'(oh(id)));
    cmp("done_pulse", int'(done), 1);
    req = 4'b0;
    step();
    cmp("gnt_released", int'(gnt), 0);
    cmp("done_cleared", int'(done), 0);
    cmp("idle", int'(busy), 0);
    cmp("sum_held", int'(res_sum), sum);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;

    tbl[0] = '{0, 3, 4, 7, 0};
    tbl[1] = '{1, 3, 2, 5, 0};
    tbl[2] = '{2, 7, 7, 6, 1};
    tbl[3] = '{0, 7, 1, 0, 1};
    tbl[4] = '{3, 0, 0, 0, 0};
    tbl[5] = '{1, 4, 5, 1, 1};

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      req  = 4'($urandom);
      op_a = 12'($urandom);
      op_b = 12'($urandom);
      step();
    end
    cmp("rst_gnt", int'(gnt), 0);
    cmp("rst_done", int'(done), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_add_a", int'(add_a), 0);
    cmp("rst_add_b", int'(add_b), 0);
    cmp("rst_res_sum", int'(res_sum), 0);
    cmp("rst_res_cout", int'(res_cout), 0);
    cmp("rst_res_id", int'(res_id), 0);
    req = '0; op_a = '0; op_b = '0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      single(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].cout);

    // Round-robin with all requests held from reset
    rst_n = 1'b0;
    step();
    set_ops(0, 1, 2);
    set_ops(1, 5, 6);
    set_ops(2, 2, 3);
    set_ops(3, 6, 1);
    req = 4'b1111;
    push(0, 3, 0); push(1, 3, 1); push(2, 5, 0); push(3, 7, 0); push(0, 3, 0);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      cmp("rr_grant", int'(gnt), int'(oh(j % 4)));
      step();
      cmp("rr_done", int'(done), 1);
      if (j == 4) req = 4'b0;
      step();
      cmp("rr_gap_gnt", int'(gnt), 0);
      cmp("rr_gap_done", int'(done), 0);
    end

    // Wrap and skip: ptr=2 after serving 0 and 1; serve 2 then contend 0 vs 3
    single(1, 1, 1, 2, 0);
    single(2, 2, 2, 4, 0);
    set_ops(0, 6, 6);
    set_ops(3, 5, 4);
    req = 4'b1001;
    push(3, 1, 1);
    push(0, 4, 1);
    step();
    cmp("wrap_grant3", int'(gnt), int'(oh(3)));
    req = 4'b0001;
    step();
    cmp("wrap_done3", int'(done), 1);
    step();
    cmp("wrap_gap", int'(gnt), 0);
    step();
    cmp("wrap_grant0", int'(gnt), int'(oh(0)));
    step();
    cmp("wrap_done0", int'(done), 1);
    req = 4'b0;
    step();

    // Reset during EXEC discards the operation and returns ptr to 0
    set_ops(1, 3, 3);
    req = 4'b0010;
    step();
    cmp("mid_grant", int'(gnt), int'(oh(1)));
    cmp("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_gnt", int'(gnt), 0);
    cmp("mid_rst_busy", int'(busy), 0);
    cmp("mid_rst_done", int'(done), 0);
    cmp("mid_rst_res_id", int'(res_id), 0);
    step();
    step();
    set_ops(0, 2, 5);
    set_ops(3, 1, 1);
    req = 4'b1001;
    push(0, 7, 0);
    rst_n = 1'b1;
    step();
    cmp("post_rst_grant0", int'(gnt), int'(oh(0)));
    step();
    cmp("post_rst_done", int'(done), 1);
    req = 4'b0;
    step();
    step();

    cmp("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
